// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter and cycle sequencer for a 256K x 16 asynchronous SRAM.
//   Port A (host path) has priority. Port B (secondary requester) is forced
//   through after MAX_HOLD consecutive A grants made while B was waiting.
//   Each access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES) -> DONE -> IDLE.
//   Every SRAM pin and every handshake output is registered.
//
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   {a,b}_req/we/addr/wdata/be   level-sensitive request and its fields
//   {a,b}_ack             one-cycle completion pulse (DONE cycle)
//   {a,b}_rdata           per-port read data, held until that port's next read
//   sram_addr/dout/din/dout_en   SRAM address and data pins
//   ram_cs_n/oe_n/we_n/lb_n/ub_n SRAM strobes, active-low
//   o_state               debug: [1:0] FSM state, [2] current owner (1 = B)

// Per-port response slice: ack pulse and the read data holding register.
module sram_arbiter_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        ack_set,
  input  logic        rd_cap,
  input  logic [15:0] din,
  output logic        ack,
  output logic [15:0] rdata
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= ack_set;
      if (rd_cap) rdata <= din;
    end
  end
endmodule

module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MAX_HOLD      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [17:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_be,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [17:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_be,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_dout_en,
  output logic        ram_cs_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_lb_n,
  output logic        ram_ub_n,
  output logic [2:0]  o_state
);

  localparam int unsigned NUM_PORTS = 2;
  localparam logic [3:0]  CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0]  HOLD      = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } req_t;

  state_t state;
  logic   owner;      // 0 = A, 1 = B
  logic   lat_we;     // latched direction; addr/wdata/be live in the pin registers
  logic [3:0] cnt;    // ACCESS down-counter
  logic [3:0] streak; // A grants made while B waited

  req_t req_a, req_b, sel;
  logic pick_b;
  logic last_access;
  logic [NUM_PORTS-1:0]       ack_set, rd_cap, ack_q;
  logic [NUM_PORTS-1:0][15:0] rdata_q;

  assign req_a = '{we: a_we, addr: a_addr, wdata: a_wdata, be: a_be};
  assign req_b = '{we: b_we, addr: b_addr, wdata: b_wdata, be: b_be};

  // B wins when alone, or when A has used up its priority streak.
  assign pick_b = b_req && (!a_req || (streak == HOLD));
  assign sel    = pick_b ? req_b : req_a;

  assign last_access = (state == ACCESS) && (cnt == 4'd0);

  // Ack and read capture happen on the edge leaving the last ACCESS cycle,
  // while OE is still low, so rdata is valid alongside ack in DONE.
  always_comb begin
    ack_set = '0;
    rd_cap  = '0;
    if (last_access) begin
      ack_set[owner] = 1'b1;
      rd_cap[owner]  = !lat_we;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      sram_arbiter_port u_port (
        .clk     (clk),
        .reset   (reset),
        .ack_set (ack_set[p]),
        .rd_cap  (rd_cap[p]),
        .din     (sram_din),
        .ack     (ack_q[p]),
        .rdata   (rdata_q[p])
      );
    end
  endgenerate

  assign a_ack   = ack_q[0];
  assign b_ack   = ack_q[1];
  assign a_rdata = rdata_q[0];
  assign b_rdata = rdata_q[1];

  // Outputs are assigned on the edge entering the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
      lat_we       <= 1'b0;
      cnt          <= '0;
      streak       <= '0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      ram_cs_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
      ram_lb_n     <= 1'b1;
      ram_ub_n     <= 1'b1;
      o_state      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            state     <= SETUP;
            owner     <= pick_b;
            lat_we    <= sel.we;
            sram_addr <= sel.addr;
            ram_cs_n  <= 1'b0;
            ram_we_n  <= 1'b1;
            o_state   <= {pick_b, SETUP};
            if (sel.we) begin
              sram_dout    <= sel.wdata;
              sram_dout_en <= 1'b1;
              ram_oe_n     <= 1'b1;
              ram_lb_n     <= ~sel.be[0];
              ram_ub_n     <= ~sel.be[1];
            end else begin
              sram_dout_en <= 1'b0;
              ram_oe_n     <= 1'b0;
              ram_lb_n     <= 1'b0;
              ram_ub_n     <= 1'b0;
            end
            if (pick_b)
              streak <= '0;
            else if (!b_req)
              streak <= '0;
            else if (streak != HOLD)
              streak <= streak + 4'd1;
          end else begin
            // b_req is low here, so the streak is over.
            streak       <= '0;
            sram_dout_en <= 1'b0;
            ram_cs_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            ram_lb_n     <= 1'b1;
            ram_ub_n     <= 1'b1;
            o_state      <= {owner, IDLE};
          end
        end

        SETUP: begin
          state   <= ACCESS;
          cnt     <= CNT_LOAD;
          o_state <= {owner, ACCESS};
          // Data and address already settled for a full cycle before WE falls.
          if (lat_we) ram_we_n <= 1'b0;
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            ram_cs_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            o_state  <= {owner, DONE};
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          // Data drivers, address and lanes were held through DONE as the
          // write hold margin; release them now.
          state        <= IDLE;
          sram_dout_en <= 1'b0;
          ram_lb_n     <= 1'b1;
          ram_ub_n     <= 1'b1;
          o_state      <= {owner, IDLE};
        end

        default: begin
          state   <= IDLE;
          o_state <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [17:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic [1:0]  a_be = 0, b_be = 0;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout, sram_din;
  logic        sram_dout_en, ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
  logic [2:0]  o_state;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic we; logic [15:0] data; } exp_t;
  exp_t a_q[$];
  exp_t b_q[$];

  logic [15:0] mem [0:262143];

  always #5 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(2), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_dout_en(sram_dout_en), .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
    .o_state(o_state)
  );

  // Asynchronous SRAM model: reads while CS and OE are low, writes lanes
  // while CS and WE are low.
  assign sram_din = (!ram_cs_n && !ram_oe_n) ? mem[sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!ram_cs_n && !ram_we_n && sram_dout_en) begin
      if (!ram_lb_n) mem[sram_addr][7:0]  = sram_dout[7:0];
      if (!ram_ub_n) mem[sram_addr][15:8] = sram_dout[15:8];
    end
  end

  // Scoreboard: every ack pops its port's expectation; reads check rdata.
  always @(negedge clk) begin
    exp_t e;
    if (a_ack) begin
      n_chk++;
      if (a_q.size() == 0) begin
        n_fail++; $display("FAIL a_ack_unexpected got ack=1 want no pending access t=%0t", $time);
      end else begin
        e = a_q.pop_front();
        if (!e.we) begin
          n_chk++;
          if (a_rdata !== e.data) begin
            n_fail++; $display("FAIL sb_a_rdata got %h want %h t=%0t", a_rdata, e.data, $time);
          end
        end
      end
    end
    if (b_ack) begin
      n_chk++;
      if (b_q.size() == 0) begin
        n_fail++; $display("FAIL b_ack_unexpected got ack=1 want no pending access t=%0t", $time);
      end else begin
        e = b_q.pop_front();
        if (!e.we) begin
          n_chk++;
          if (b_rdata !== e.data) begin
            n_fail++; $display("FAIL sb_b_rdata got %h want %h t=%0t", b_rdata, e.data, $time);
          end
        end
      end
    end
    if (a_ack || b_ack) begin
      n_chk++;
      if (a_ack && b_ack) begin
        n_fail++; $display("FAIL acks_overlap got a=1 b=1 want one t=%0t", $time);
      end
    end
    if (!ram_oe_n) begin
      n_chk++;
      if (sram_dout_en !== 1'b0) begin
        n_fail++; $display("FAIL oe_with_dout_en got en=%b want 0 t=%0t", sram_dout_en, $time);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_strobes got %b want 11111", {ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n});
    end
    n_chk++;
    if ({sram_dout_en, a_ack, b_ack, o_state} !== 6'd0) begin
      n_fail++; $display("FAIL reset_ctrl got en=%b acks=%b%b st=%0d want 0", sram_dout_en, a_ack, b_ack, o_state);
    end
    n_chk++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0 || sram_addr !== 18'h0 || sram_dout !== 16'h0) begin
      n_fail++; $display("FAIL reset_data got ar=%h br=%h ad=%h do=%h want 0", a_rdata, b_rdata, sram_addr, sram_dout);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    mem[18'h00ABC] = 16'h1234;
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 18'h00ABC;
    a_q.push_back('{we: 1'b0, data: 16'h1234});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (ram_oe_n !== ((k >= 1 && k <= 3) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL rd_oe_n cycle %0d got %b", k, ram_oe_n);
      end
      n_chk++;
      if (a_ack !== (k == 4)) begin
        n_fail++; $display("FAIL rd_a_ack cycle %0d got %b want %b", k, a_ack, k == 4);
      end
      if (k == 4) begin
        a_req = 0;
        n_chk++;
        if (a_rdata !== 16'h1234 || b_rdata !== 16'h0000) begin
          n_fail++; $display("FAIL rd_rdata got a=%h b=%h want a=1234 b=0000", a_rdata, b_rdata);
        end
      end
    end
  endtask

  task automatic test_b_byte_write();
    mem[18'h3FFFF] = 16'h1122;
    @(posedge clk); #1;
    b_req = 1; b_we = 1; b_addr = 18'h3FFFF; b_wdata = 16'hBEEF; b_be = 2'b10;
    b_q.push_back('{we: 1'b1, data: 16'h0});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (ram_ub_n !== ((k >= 1 && k <= 4) ? 1'b0 : 1'b1) || ram_lb_n !== 1'b1) begin
        n_fail++; $display("FAIL bw_lanes cycle %0d got ub=%b lb=%b", k, ram_ub_n, ram_lb_n);
      end
      n_chk++;
      if (ram_we_n !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL bw_we_n cycle %0d got %b", k, ram_we_n);
      end
      n_chk++;
      if (b_ack !== (k == 4)) begin
        n_fail++; $display("FAIL bw_b_ack cycle %0d got %b want %b", k, b_ack, k == 4);
      end
      if (k == 4) b_req = 0;
    end
    n_chk++;
    if (mem[18'h3FFFF] !== 16'hBE22) begin
      n_fail++; $display("FAIL bw_mem got %h want be22", mem[18'h3FFFF]);
    end
    n_chk++;
    if (a_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL bw_a_rdata_kept got %h want 1234", a_rdata);
    end
    b_we = 0;
  endtask

  task automatic test_contention();
    string got = "";
    int n_ack = 0;
    logic pa = 0, pb = 0;
    mem[18'h00100] = 16'hAAAA;
    mem[18'h00200] = 16'hBBBB;
    for (int i = 0; i < 8; i++) a_q.push_back('{we: 1'b0, data: 16'hAAAA});
    for (int i = 0; i < 2; i++) b_q.push_back('{we: 1'b0, data: 16'hBBBB});
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 18'h00100;
    b_req = 1; b_we = 0; b_addr = 18'h00200;
    for (int k = 0; k < 200 && n_ack < 10; k++) begin
      @(negedge clk);
      n_chk++;
      if ((a_ack && pa) || (b_ack && pb)) begin
        n_fail++; $display("FAIL ct_pulse cycle %0d got a=%b b=%b held", k, a_ack, b_ack);
      end
      if (a_ack) begin got = {got, "A"}; n_ack++; end
      if (b_ack) begin got = {got, "B"}; n_ack++; end
      pa = a_ack; pb = b_ack;
    end
    a_req = 0; b_req = 0;
    n_chk++;
    if (got != "AAAABAAAAB") begin
      n_fail++; $display("FAIL ct_order got %s want AAAABAAAAB", got);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int setups = 0;
    mem[18'h01000] = 16'h0F0F;
    mem[18'h01001] = 16'hF0F0;
    a_q.push_back('{we: 1'b0, data: 16'h0F0F});
    a_q.push_back('{we: 1'b0, data: 16'hF0F0});
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 18'h01000;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      n_chk++;
      if ((o_state[1:0] == 2'd1) !== (k == 1 || k == 6)) begin
        n_fail++; $display("FAIL b2b_setup cycle %0d got state=%0d", k, o_state[1:0]);
      end
      n_chk++;
      if (a_ack !== (k == 4 || k == 9)) begin
        n_fail++; $display("FAIL b2b_ack cycle %0d got %b", k, a_ack);
      end
      if (o_state[1:0] == 2'd1) setups++;
      if (k == 4) a_addr = 18'h01001;
      if (k == 9) a_req = 0;
    end
    n_chk++;
    if (setups != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d want 2", setups);
    end
  endtask

  task automatic test_be00_write();
    mem[18'h00077] = 16'hCAFE;
    a_q.push_back('{we: 1'b1, data: 16'h0});
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 18'h00077; a_wdata = 16'h0000; a_be = 2'b00;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (ram_lb_n !== 1'b1 || ram_ub_n !== 1'b1) begin
        n_fail++; $display("FAIL be0_lanes cycle %0d got lb=%b ub=%b want 1 1", k, ram_lb_n, ram_ub_n);
      end
      n_chk++;
      if (a_ack !== (k == 4)) begin
        n_fail++; $display("FAIL be0_ack cycle %0d got %b want %b", k, a_ack, k == 4);
      end
      if (k == 4) a_req = 0;
    end
    n_chk++;
    if (mem[18'h00077] !== 16'hCAFE) begin
      n_fail++; $display("FAIL be0_mem got %h want cafe", mem[18'h00077]);
    end
    a_we = 0;
  endtask

  task automatic test_reset_mid_write();
    bit seen = 0;
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 18'h00055; a_wdata = 16'h5555; a_be = 2'b11;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (o_state[1:0] == 2'd2) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL rmw_reach_access got no ACCESS state want ACCESS within 10 cycles");
    end
    reset = 0;
    a_req = 0; a_we = 0;
    #1;
    n_chk++;
    if (ram_we_n !== 1'b1 || ram_cs_n !== 1'b1 || sram_dout_en !== 1'b0 || o_state !== 3'd0) begin
      n_fail++; $display("FAIL rmw_async got we=%b cs=%b en=%b st=%0d want 1 1 0 0", ram_we_n, ram_cs_n, sram_dout_en, o_state);
    end
    n_chk++;
    if (a_rdata !== 16'h0) begin
      n_fail++; $display("FAIL rmw_rdata_clr got %h want 0", a_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (a_ack !== 1'b0) begin
        n_fail++; $display("FAIL rmw_no_ack cycle %0d got %b want 0", k, a_ack);
      end
    end
    a_q.push_back('{we: 1'b0, data: 16'h1234});
    @(posedge clk); #1;
    a_req = 1; a_we = 0; a_addr = 18'h00ABC;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (a_ack !== (k == 4)) begin
        n_fail++; $display("FAIL rmw_fresh_ack cycle %0d got %b want %b", k, a_ack, k == 4);
      end
      if (k == 4) a_req = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_b_byte_write();
    test_contention();
    test_back_to_back();
    test_be00_write();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    n_chk++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain got a=%0d b=%0d pending want 0", a_q.size(), b_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's 256K x 16 asynchronous SRAM. Port A is the 4A host path (memory_interface side) and has priority. Port B is a secondary on-chip requester (VDP/DMA/loader). The block owns every SRAM pin, serialises accesses, generates the CS/OE/WE/byte-lane strobes with setup and hold margins, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- ACCESS_CYCLES, 2: cycles the OE or WE strobe is held active. Legal range 1..15.
- MAX_HOLD, 4: consecutive A grants allowed while B is waiting before B is forced to win. Legal range 1..15.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- a_req / b_req  input  1  access request; level-sensitive.
- a_we / b_we  input  1  1 = write, 0 = read.
- a_addr / b_addr  input  18  word address.
- a_wdata / b_wdata  input  16  write data.
- a_be / b_be  input  2  byte enables, active-high: [0] = low byte, [1] = high byte. Used on writes only.
- a_ack / b_ack  output  1  one-cycle completion pulse.
- a_rdata / b_rdata  output  16  read data. Held until that port's next read completes.
- sram_addr  output  18  SRAM address pins.
- sram_dout  output  16  data driven to the SRAM.
- sram_din  input  16  data read from the SRAM.
- sram_dout_en  output  1  enables the DAT pin drivers.
- ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  output  1  SRAM strobes, active-low.
- o_state  output  3  debug: [1:0] FSM state, [2] current owner (1 = B).

## Operation
- FSM states: IDLE=0, SETUP=1, ACCESS=2, DONE=3. All outputs are registered.
- IDLE:
  - All strobes are high and sram_dout_en=0.
  - If any req is high, pick a winner and latch its we, addr, wdata and be into internal registers, then go to SETUP.
- Arbitration (in IDLE only):
  - Only A requesting: A wins. Only B requesting: B wins.
  - Both requesting: A wins, unless the streak counter equals MAX_HOLD, in which case B wins.
- Streak counter:
  - Increments on each A grant made while b_req is high.
  - Clears on any B grant, and in any IDLE cycle where b_req is low.
  - Saturates at MAX_HOLD.
- SETUP (1 cycle):
  - ram_cs_n=0 and sram_addr is driven from the latch.
  - Read: ram_oe_n=0, and ram_lb_n = ram_ub_n = 0.
  - Write: sram_dout_en=1 and sram_dout = latched wdata. ram_lb_n = ~be[0], ram_ub_n = ~be[1]. ram_we_n stays 1.
- ACCESS (ACCESS_CYCLES cycles, counted by an internal down-counter):
  - Read: ram_oe_n=0. On the last ACCESS cycle, register sram_din into the owner's rdata.
  - Write: ram_we_n=0.
- DONE (1 cycle):
  - ram_we_n=1, ram_oe_n=1, ram_cs_n=1.
  - On a write, sram_dout_en stays 1 and address and data are held. This is the hold margin.
  - The owner's ack=1. Next state is IDLE.
- Requester rule:
  - Keep req and all request fields stable until ack.
  - Drive req low in the cycle after ack unless a further access with new fields is intended. A req still high in that IDLE cycle is treated as a new request.
- Fields are latched at grant. Dropping req after the grant does not abort the access; ack still pulses.
- A write with be=00 runs a full cycle with both lane strobes high and acks normally. No data is written.
- The two rdata registers are independent. A B read never disturbs a_rdata, and vice versa.

## Timing
- With ACCESS_CYCLES=N, a request seen in IDLE at cycle 0 produces: SETUP at cycle 1, ACCESS at cycles 2..N+1, DONE/ack at cycle N+2, IDLE at cycle N+3.
- Minimum access period is N+3 cycles (5 cycles, 50 ns, at default).
- rdata is valid in the ack cycle.
- sram_addr and byte lanes are stable from SETUP through DONE.
- WE low never overlaps an sram_dout change. OE is never low while sram_dout_en=1.
- Reset (asynchronous, any state, including mid-write) forces:
  - state IDLE, strobes high, sram_dout_en=0;
  - both acks 0, both rdata 0, sram_addr 0, sram_dout 0;
  - streak counter 0, o_state 0.
- No ack is issued for an access aborted by reset.

## Test plan
- Single A read (N=2): SRAM model holds 0x1234 at 0x00ABC; a_req with addr 0x00ABC at cycle 0. Required: ram_oe_n low in cycles 1-3, a_ack high only in cycle 4, a_rdata=0x1234, b_rdata unchanged.
- B byte write: be=10, data 0xBEEF, addr 0x3FFFF. Required: ram_ub_n=0 and ram_lb_n=1 in SETUP through DONE, ram_we_n low in cycles 2-3 only. The model's high byte becomes 0xBE and its low byte is unchanged.
- Contention: a_req and b_req held high continuously with MAX_HOLD=4. Required grant order is A,A,A,A,B,A,A,A,A,B. Each ack is a single-cycle pulse, and the two acks are never high together.
- Back-to-back A: req held high after ack with a new address. Required: second SETUP exactly one IDLE cycle after the first DONE, and a 5-cycle period.
- Reset mid-write: reset asserted during ACCESS. Required: within the same cycle (asynchronous), ram_we_n=1, ram_cs_n=1, sram_dout_en=0, o_state=0. No ack afterwards. After reset is released, a fresh request completes normally.
- be=00 write: all lane strobes stay high, the model is unchanged, and ack arrives at cycle 4.
